// File: rtl/channel_readout_arbiter_pkg.sv
// Shared constants and state encoding for the channel readout arbiter.
// Imported by the round-robin picker and the arbiter top.
package channel_readout_arbiter_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int DATA_W = 120;
    localparam int CNT_W  = 10;
    localparam int BCNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/channel_readout_arbiter_rr_pick4.sv
// Combinational round-robin picker: first eligible channel at or after pointer.
// Ports: eligible[3:0], pointer[1:0] in; grant[1:0], found out.
module channel_readout_arbiter_rr_pick4
    import channel_readout_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] eligible,
    input  logic [CH_W-1:0]   pointer,
    output logic [CH_W-1:0]   grant,
    output logic              found
);

    logic [CH_W-1:0] idx;

    // Scan from the farthest offset down so the nearest eligible one wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = pointer + CH_W'(k);
            if (eligible[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_readout_arbiter.sv
// Round-robin burst scheduler draining four FWFT channel FIFOs into one tagged
// valid/ready stream. Ports: clk160/reset_n, per-channel enable/empty/count/data
// in, one-hot channel_data_read out, out_data/out_channel/out_last/out_valid with
// out_ready in, busy and 32-bit accepted word_count out.
module channel_readout_arbiter
    import channel_readout_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic                     clk160,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        enable,
    input  logic [NUM_CH-1:0]        channel_fifo_empty,
    input  logic [NUM_CH*CNT_W-1:0]  channel_data_counter,
    input  logic [NUM_CH*DATA_W-1:0] channel_data,
    output logic [NUM_CH-1:0]        channel_data_read,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_channel,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [31:0]              word_count
);

    localparam logic [BCNT_W-1:0] BURST_END = BCNT_W'(MAX_BURST - 1);

    state_t              state, state_n;
    logic [CH_W-1:0]     grant, grant_n;
    logic [CH_W-1:0]     rr_ptr, rr_ptr_n;
    logic [BCNT_W-1:0]   burst_cnt, burst_cnt_n;
    logic [CH_W-1:0]     pick;
    logic                found;
    logic [NUM_CH-1:0]   eligible;
    logic                slot_free;
    logic                pop;
    logic                last;
    logic                abandon;
    logic [CNT_W-1:0]    grant_cnt;
    logic [DATA_W-1:0]   grant_data;

    assign eligible   = enable & ~channel_fifo_empty;
    assign slot_free  = ~out_valid | out_ready;
    assign grant_cnt  = channel_data_counter[grant*CNT_W +: CNT_W];
    assign grant_data = channel_data[grant*DATA_W +: DATA_W];
    assign busy       = (state != IDLE);

    // A disabled channel still hands over the word it pops this cycle,
    // flagged as the last of its burst.
    assign pop     = (state == GRANT) & slot_free & ~channel_fifo_empty[grant];
    assign last    = (burst_cnt == BURST_END) |
                     (grant_cnt == CNT_W'(1)) |
                     ~enable[grant];
    assign abandon = (state == GRANT) & ~pop & ~eligible[grant];

    channel_readout_arbiter_rr_pick4 u_pick (
        .eligible (eligible),
        .pointer  (rr_ptr),
        .grant    (pick),
        .found    (found)
    );

    always_comb begin
        channel_data_read = '0;
        if (pop) channel_data_read[grant] = 1'b1;
    end

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n     = GRANT;
                    grant_n     = pick;
                    burst_cnt_n = '0;
                end
            end
            GRANT: begin
                if (pop) burst_cnt_n = burst_cnt + BCNT_W'(1);
                if ((pop & last) | abandon) begin
                    state_n  = IDLE;
                    rr_ptr_n = grant + CH_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            out_data    <= '0;
            out_channel <= '0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
        end else if (pop) begin
            out_data    <= grant_data;
            out_channel <= grant;
            out_last    <= last;
            out_valid   <= 1'b1;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            word_count <= '0;
        end else if (out_valid & out_ready) begin
            word_count <= word_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Self-checking bench for channel_readout_arbiter: FIFO queues feed the DUT,
// a burst-level round-robin model predicts the accepted word stream.
module tb_channel_readout_arbiter;
    import channel_readout_arbiter_pkg::*;

    localparam int MB = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        ch;
        logic              last;
    } rec_t;

    logic                     clk160 = 1'b0;
    logic                     reset_n;
    logic [NUM_CH-1:0]        enable;
    logic [NUM_CH-1:0]        channel_fifo_empty;
    logic [NUM_CH*CNT_W-1:0]  channel_data_counter;
    logic [NUM_CH*DATA_W-1:0] channel_data;
    logic [NUM_CH-1:0]        channel_data_read;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_channel;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;
    logic [31:0]              word_count;

    word_t fq[NUM_CH][$];
    word_t mq[NUM_CH][$];
    rec_t  rx[$];
    int    rx_cyc[$];
    rec_t  ex[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mptr = 0;
    int          wc_exp = 0;
    logic [3:0]  rd_s = '0;
    logic        prev_stall = 1'b0;
    logic [127:0] snap = '0;

    always #5 clk160 = ~clk160;

    channel_readout_arbiter #(.MAX_BURST(MB)) dut (
        .clk160               (clk160),
        .reset_n              (reset_n),
        .enable               (enable),
        .channel_fifo_empty   (channel_fifo_empty),
        .channel_data_counter (channel_data_counter),
        .channel_data         (channel_data),
        .channel_data_read    (channel_data_read),
        .out_data             (out_data),
        .out_channel          (out_channel),
        .out_last             (out_last),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .busy                 (busy),
        .word_count           (word_count)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_CH; i++) begin
            channel_fifo_empty[i] = (fq[i].size() == 0);
            channel_data_counter[i*CNT_W +: CNT_W] = CNT_W'(fq[i].size());
            channel_data[i*DATA_W +: DATA_W] = (fq[i].size() > 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic fill(input int ch, input int n);
        logic [127:0] r;
        for (int j = 0; j < n; j++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            fq[ch].push_back(r[DATA_W-1:0]);
            mq[ch].push_back(r[DATA_W-1:0]);
        end
        drive();
    endtask

    task automatic flush(input int ch);
        fq[ch].delete();
        mq[ch].delete();
        drive();
    endtask

    // Observe the bus mid-cycle: pop legality, stall hold, accepted words.
    task automatic sample();
        logic bad;
        if (!reset_n) begin
            prev_stall = 1'b0;
            rd_s = '0;
            return;
        end
        bad = !$onehot0(channel_data_read) ||
              ((channel_data_read != 0) && out_valid && !out_ready) ||
              ((channel_data_read & channel_fifo_empty) != 0) ||
              ((channel_data_read != 0) && !busy);
        chk("rd_legal", 128'(bad), 128'(0));
        if (prev_stall)
            chk("hold", {out_valid, out_channel, out_last, out_data}, snap);
        if (out_valid && out_ready) begin
            rx.push_back('{data: out_data, ch: out_channel, last: out_last});
            rx_cyc.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        snap = {out_valid, out_channel, out_last, out_data};
        rd_s = channel_data_read;
    endtask

    task automatic tick();
        @(negedge clk160);
        sample();
        @(posedge clk160);
        cyc++;
        #1;
        for (int i = 0; i < NUM_CH; i++)
            if (rd_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        drive();
        #1;
    endtask

    // Burst-level model: round robin over channels with data, each burst
    // takes min(MB, fill) words, pointer moves past the served channel.
    task automatic build_expected(input logic [3:0] mask);
        int g, n, c;
        bit fnd;
        forever begin
            fnd = 0;
            g = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                c = (mptr + k) % NUM_CH;
                if (!fnd && mask[c] && mq[c].size() > 0) begin
                    g = c;
                    fnd = 1;
                end
            end
            if (!fnd) break;
            n = (mq[g].size() < MB) ? mq[g].size() : MB;
            for (int j = 0; j < n; j++)
                ex.push_back('{data: mq[g].pop_front(), ch: 2'(g), last: (j == n - 1)});
            mptr = (g + 1) % NUM_CH;
        end
    endtask

    task automatic run_check(input string tag, input bit rand_ready);
        bit done;
        int n;
        build_expected(enable);
        done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            done = !out_valid && !busy;
            for (int i = 0; i < NUM_CH; i++)
                if (enable[i] && fq[i].size() > 0) done = 0;
        end
        chk({tag, "_drained"}, 128'(done), 128'(1));
        out_ready = 1'b1;
        chk({tag, "_count"}, 128'(rx.size()), 128'(ex.size()));
        n = (rx.size() < ex.size()) ? rx.size() : ex.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_word%0d", tag, i), 128'(rx[i]), 128'(ex[i]));
        wc_exp += ex.size();
        chk({tag, "_word_count"}, 128'(word_count), 128'(wc_exp));
    endtask

    task automatic clear_rx();
        rx.delete();
        rx_cyc.delete();
        ex.delete();
    endtask

    task automatic wait_words(input string tag, input int k);
        int base;
        bit hit;
        base = int'(word_count);
        hit = 0;
        for (int t = 0; t < 200 && !hit; t++) begin
            tick();
            hit = (int'(word_count) >= base + k);
        end
        chk({tag, "_progress"}, 128'(hit), 128'(1));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_data"}, 128'(out_data), 128'(0));
        chk({tag, "_ch"}, 128'(out_channel), 128'(0));
        chk({tag, "_last"}, 128'(out_last), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_wc"}, 128'(word_count), 128'(0));
        chk({tag, "_rd"}, 128'(channel_data_read), 128'(0));
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        mptr = 0;
        wc_exp = 0;
        clear_rx();
        tick();
    endtask

    initial begin
        int popped;
        logic [3:0] mask;
        reset_n = 1'b0;
        enable = '0;
        out_ready = 1'b0;
        channel_fifo_empty = '1;
        channel_data_counter = '0;
        channel_data = '0;
        drive();
        repeat (3) tick();
        check_zero("reset");
        reset_n = 1'b1;
        tick();

        // 20 words on ch0: bursts of 16 and 4, one idle cycle between.
        enable = 4'hF;
        out_ready = 1'b1;
        fill(0, 20);
        run_check("t2", 0);
        if (rx_cyc.size() >= 17) begin
            chk("t2_rate", 128'(rx_cyc[1] - rx_cyc[0]), 128'(1));
            chk("t2_gap", 128'(rx_cyc[16] - rx_cyc[15]), 128'(2));
        end
        clear_rx();

        // Three words on every channel, fresh pointer.
        reset_pulse();
        for (int c = 0; c < NUM_CH; c++) fill(c, 3);
        run_check("t3", 0);
        clear_rx();

        // Asynchronous reset in the middle of a burst.
        fill(3, 8);
        wait_words("t1", 2);
        reset_n = 1'b0;
        #1;
        check_zero("t1_async");
        for (int c = 0; c < NUM_CH; c++) flush(c);
        clear_rx();
        tick();
        tick();
        reset_n = 1'b1;
        mptr = 0;
        wc_exp = 0;
        tick();
        fill(3, 2);
        fill(0, 2);
        run_check("t1_ptr", 0);
        clear_rx();

        // Downstream stall for five cycles mid-burst.
        fill(2, 10);
        wait_words("t4", 3);
        out_ready = 1'b0;
        snap = {1'b0, 7'd0, out_data};
        for (int t = 0; t < 5; t++) begin
            tick();
            chk($sformatf("t4_stable%0d", t), 128'(out_data), 128'(snap[DATA_W-1:0]));
            chk($sformatf("t4_nopop%0d", t), 128'(channel_data_read), 128'(0));
        end
        out_ready = 1'b1;
        run_check("t4", 0);
        clear_rx();

        // Disable ch1 during its burst: the word popped then closes it.
        fill(1, 10);
        fill(2, 2);
        wait_words("t5", 3);
        popped = 10 - fq[1].size();
        enable = 4'b1101;
        tick();
        for (int j = 0; j <= popped; j++)
            ex.push_back('{data: mq[1].pop_front(), ch: 2'd1, last: (j == popped)});
        flush(1);
        mptr = 2;
        run_check("t5", 0);
        clear_rx();
        enable = 4'hF;

        // Pointer parked at 3, only ch0 has data: wrap to ch0.
        fill(2, 3);
        run_check("t6_pre", 0);
        clear_rx();
        fill(0, 4);
        tick();
        chk("t6_busy", 128'(busy), 128'(1));
        chk("t6_rd", 128'(channel_data_read), 128'(4'b0001));
        run_check("t6", 0);
        clear_rx();

        // Random fills, masks and backpressure.
        for (int it = 0; it < 6; it++) begin
            mask = 4'($urandom_range(1, 15));
            enable = mask;
            for (int c = 0; c < NUM_CH; c++) fill(c, $urandom_range(0, 40));
            run_check($sformatf("rnd%0d", it), 1);
            clear_rx();
            for (int c = 0; c < NUM_CH; c++) flush(c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
